pulse_sequencer: RTL

//   Run-time programmable two-pulse (Hahn echo) sequencer for the PLL-clocked pulse path.

---
 rtl/pulse_sequencer_if.sv | 24 ++
 rtl/pulse_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer_if.sv
// Config handshake bundle for pulse_sequencer.
// Ports: cfg_valid/cfg_ready handshake, timing fields (width, delay, period) and nrep.
interface pulse_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_period;
  logic [15:0]      cfg_nrep;

  modport master (
    output cfg_valid, cfg_width, cfg_delay,
    output cfg_period, cfg_nrep,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_width, cfg_delay,
    input  cfg_period, cfg_nrep,
    output cfg_ready
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Two-pulse (Hahn echo) sequencer with shadowed run-time config.
// Ports: clk, rst_n (sync low), lock, cfg (slave), start, stop ->
//   pulse, recv_gate, sync, busy, done, err_cfg (all registered).
module pulse_sequencer #(
  parameter int CNT_W      = 32,
  parameter int DEF_WIDTH  = 30,
  parameter int DEF_DELAY  = 200,
  parameter int DEF_PERIOD = 200000,
  parameter int RX_BLANK   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  pulse_sequencer_if.slave cfg,
  input  logic start,
  input  logic stop,
  output logic pulse,
  output logic recv_gate,
  output logic sync,
  output logic busy,
  output logic done,
  output logic err_cfg
);
  localparam int DW      = CNT_W + 2;
  localparam int DEF_P2S = DEF_WIDTH + DEF_DELAY;
  localparam int DEF_P2E = DEF_P2S + 2 * DEF_WIDTH;
  localparam int DEF_RX  = DEF_P2E + RX_BLANK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t r_state, w_next;

  logic [CNT_W-1:0] r_c, r_w, r_period;
  logic [DW-1:0]    r_p2s, r_p2e, r_rxon;
  logic [15:0]      r_nrep, r_rep;

  logic             r_pend;
  logic [CNT_W-1:0] r_pw, r_pperiod;
  logic [DW-1:0]    r_pp2s, r_pp2e, r_prxon;
  logic [15:0]      r_pnrep;

  logic r_pulse, r_recv, r_sync, r_busy;
  logic r_fin, r_done, r_err;

  logic          w_acc, w_ok, w_wrap, w_last;
  logic          w_go, w_fin;
  logic [DW-1:0] w_p2s, w_p2e, w_rxon, w_c;

  assign w_acc  = cfg.cfg_valid & ~r_pend;
  assign w_p2s  = {2'b0, cfg.cfg_width}
                + {2'b0, cfg.cfg_delay};
  assign w_p2e  = w_p2s
                + {1'b0, cfg.cfg_width, 1'b0};
  assign w_rxon = w_p2e + DW'(RX_BLANK);
  assign w_ok   = (cfg.cfg_width != '0)
                && ({2'b0, cfg.cfg_period} > w_rxon);

  assign w_c    = {2'b0, r_c};
  assign w_wrap = (r_c == r_period - CNT_W'(1));
  assign w_last = (r_nrep != 16'd0)
                && (r_rep == r_nrep - 16'd1);
  // Gating with lock blanks the outputs on the
  // very edge the lock loss is sampled.
  assign w_go   = (r_state != S_IDLE) && lock;

  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && lock && !stop)
          w_next = S_RUN;
      end
      S_RUN: begin
        if (!lock) begin
          w_next = S_IDLE;
        end else if (w_wrap && w_last) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end else if (stop) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (!lock || w_wrap)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_rep    <= '0;
      r_w      <= CNT_W'(DEF_WIDTH);
      r_period <= CNT_W'(DEF_PERIOD);
      r_p2s    <= DW'(DEF_P2S);
      r_p2e    <= DW'(DEF_P2E);
      r_rxon   <= DW'(DEF_RX);
      r_nrep   <= '0;
      r_pend   <= 1'b0;
      r_pw     <= '0;
      r_pperiod <= '0;
      r_pp2s   <= '0;
      r_pp2e   <= '0;
      r_prxon  <= '0;
      r_pnrep  <= '0;
      r_pulse  <= 1'b0;
      r_recv   <= 1'b0;
      r_sync   <= 1'b0;
      r_busy   <= 1'b0;
      r_fin    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_acc & ~w_ok;

      if (r_state == S_IDLE || w_next == S_IDLE) begin
        r_c   <= '0;
        r_rep <= '0;
      end else if (w_wrap) begin
        r_c   <= '0;
        r_rep <= r_rep + 16'd1;
      end else begin
        r_c <= r_c + CNT_W'(1);
      end

      r_pulse <= w_go & ((w_c < {2'b0, r_w})
               | ((w_c >= r_p2s) & (w_c < r_p2e)));
      r_recv  <= w_go & (w_c >= r_rxon)
               & (r_c < r_period);
      r_sync  <= w_go & (r_c == '0);
      r_busy  <= w_go;
      // done lines up with the cycle busy falls
      r_fin   <= w_fin;
      r_done  <= r_fin;

      if (w_acc && w_ok) begin
        if (r_state == S_IDLE) begin
          r_w      <= cfg.cfg_width;
          r_period <= cfg.cfg_period;
          r_p2s    <= w_p2s;
          r_p2e    <= w_p2e;
          r_rxon   <= w_rxon;
          r_nrep   <= cfg.cfg_nrep;
        end else begin
          r_pend    <= 1'b1;
          r_pw      <= cfg.cfg_width;
          r_pperiod <= cfg.cfg_period;
          r_pp2s    <= w_p2s;
          r_pp2e    <= w_p2e;
          r_prxon   <= w_rxon;
          r_pnrep   <= cfg.cfg_nrep;
        end
      end

      // w_acc needs !r_pend, so this never
      // collides with the load above.
      if (r_state != S_IDLE && w_wrap && r_pend) begin
        r_pend   <= 1'b0;
        r_w      <= r_pw;
        r_period <= r_pperiod;
        r_p2s    <= r_pp2s;
        r_p2e    <= r_pp2e;
        r_rxon   <= r_prxon;
        r_nrep   <= r_pnrep;
      end
    end
  end

  assign cfg.cfg_ready = ~r_pend;
  assign pulse         = r_pulse;
  assign recv_gate     = r_recv;
  assign sync          = r_sync;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_cfg       = r_err;
endmodule
